cv32e40p_obi_mem_responder: RTL and testbench

// - Responder (memory) end of the core's OBI-style instr/data interface (req/gnt/rvalid, we/be/addr/wdata/rdata).
// - Word-organised RAM: accepts granted requests, returns in-order responses after a fixed latency.
// - Throttles grants via a stall input and an outstanding-transaction limit.
// - Used as a test/integration memory behind the core's instruction or data port.

---
 rtl/cv32e40p_obi_pkg.sv | 47 ++++
 rtl/cv32e40p_obi_resp_pipe.sv | 42 ++++
 rtl/cv32e40p_obi_mem_responder.sv | 91 +++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_pkg
// Description : Shared types and constants for the OBI memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_obi_pkg;

    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;
    localparam int OBI_ADDR_W = 32;

    typedef struct packed {
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
    } obi_rsp_t;

    // One slot of the response delay line.
    typedef struct packed {
        logic     valid;
        obi_rsp_t rsp;
    } obi_pipe_entry_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [OBI_DATA_W-1:0] be_merge(
        input logic [OBI_DATA_W-1:0] old_word,
        input logic [OBI_DATA_W-1:0] new_word,
        input logic [OBI_BE_W-1:0]   be
    );
        logic [OBI_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < OBI_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage : cv32e40p_obi_pkg
`default_nettype wire

// File: rtl/cv32e40p_obi_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_resp_pipe
// Description : Fixed-latency delay line carrying {valid, response}. An entry
//               written at the end of cycle t appears on the output during
//               cycle t+DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_resp_pipe
    import cv32e40p_obi_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     i_valid,
    input  obi_rsp_t i_rsp,
    output logic     o_valid,
    output obi_rsp_t o_rsp
);

    obi_pipe_entry_t r_stage [DEPTH];

    // Shift responses one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= '{valid: i_valid, rsp: i_rsp};
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1].valid;
    assign o_rsp   = r_stage[DEPTH-1].rsp;

endmodule : cv32e40p_obi_resp_pipe
`default_nettype wire

// File: rtl/cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_obi_mem_responder
// Description : OBI responder backed by a word-organised RAM. Grants are
//               throttled by stall_i and an outstanding-transaction limit;
//               responses return in order after RESP_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_obi_mem_responder
    import cv32e40p_obi_pkg::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int RESP_LAT        = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [OBI_BE_W-1:0]   be_i,
    input  logic [OBI_ADDR_W-1:0] addr_i,
    input  logic [OBI_DATA_W-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [OBI_DATA_W-1:0] rdata_o
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [OBI_DATA_W-1:0] r_mem [MEM_WORDS];
    logic [c_CNT_W-1:0]    r_cnt;

    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_xfer;
    logic                  w_rvalid;
    logic                  w_pipe_valid;
    obi_rsp_t              w_pipe_in;
    obi_rsp_t              w_pipe_out;
    logic                  w_unused_addr;

    // Upper address bits alias onto the RAM; the byte offset is ignored.
    assign w_idx         = addr_i[c_IDX_W+1:2];
    assign w_unused_addr = ^{addr_i[OBI_ADDR_W-1:c_IDX_W+2], addr_i[1:0]};

    // A retiring response frees a slot in the same cycle, so grant may bypass the limit.
    assign w_rvalid = w_pipe_valid & ~rst_i;
    assign gnt_o    = req_i & ~stall_i & ~rst_i &
                      ((r_cnt < c_CNT_W'(MAX_OUTSTANDING)) | w_rvalid);
    assign w_xfer   = req_i & gnt_o;

    // Byte-enabled write at the end of the transfer cycle; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_xfer && we_i) begin
            r_mem[w_idx] <= be_merge(r_mem[w_idx], wdata_i, be_i);
        end
    end

    // Reads sample the whole word now; write responses carry zero data.
    assign w_pipe_in.rdata = we_i ? '0 : r_mem[w_idx];

    cv32e40p_obi_resp_pipe #(
        .DEPTH (RESP_LAT)
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (w_xfer),
        .i_rsp   (w_pipe_in),
        .o_valid (w_pipe_valid),
        .o_rsp   (w_pipe_out)
    );

    // Track granted-but-unanswered transactions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_xfer, w_rvalid})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rvalid_o = w_rvalid;
    assign rdata_o  = w_rvalid ? w_pipe_out.rdata : '0;

endmodule : cv32e40p_obi_mem_responder
`default_nettype wire

// File: tb/tb_cv32e40p_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_obi_mem_responder
// Description : Self-checking bench with a response scoreboard and a
//               reference memory model for the OBI memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_obi_mem_responder;

    localparam int MEM_WORDS       = 16;
    localparam int RESP_LAT        = 3;
    localparam int MAX_OUTSTANDING = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    cv32e40p_obi_mem_responder #(
        .MEM_WORDS       (MEM_WORDS),
        .RESP_LAT        (RESP_LAT),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem_m [MEM_WORDS];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, update the model.
    task automatic step(input logic req, input logic stall, input logic we,
                        input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic granted);
        logic exp_rv;
        logic exp_gnt;
        exp_t e;
        int   idx;
        req_i   = req;
        stall_i = stall;
        we_i    = we;
        be_i    = be;
        addr_i  = addr;
        wdata_i = wdata;
        @(negedge clk_i);
        exp_rv  = (sb.size() > 0) && (sb[0].due == cyc);
        exp_gnt = req && !stall && ((sb.size() < MAX_OUTSTANDING) || exp_rv);
        check_eq("gnt", {31'b0, gnt_o}, {31'b0, exp_gnt});
        check_eq("rvalid", {31'b0, rvalid_o}, {31'b0, exp_rv});
        if (exp_rv) begin
            e = sb.pop_front();
            check_eq("rdata", rdata_o, e.data);
        end else begin
            check_eq("rdata_idle", rdata_o, 32'h0);
        end
        if (exp_gnt) begin
            idx = int'((addr >> 2) % MEM_WORDS);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                sb.push_back('{due: cyc + RESP_LAT, data: 32'h0});
            end else begin
                sb.push_back('{due: cyc + RESP_LAT, data: mem_m[idx]});
            end
        end
        granted = exp_gnt;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Hold a request until it is granted, within a bounded number of cycles.
    task automatic xfer(input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic g;
        g = 1'b0;
        for (int k = 0; k < 20 && !g; k++) begin
            step(1'b1, 1'b0, we, be, addr, wdata, g);
        end
        if (!g) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout addr 0x%08h: got no grant expected grant", addr);
        end
    endtask

    task automatic idle(input int n);
        logic g;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, g);
    endtask

    // One reset cycle with a pending write request that must be ignored.
    task automatic do_reset();
        rst_i   = 1'b1;
        req_i   = 1'b1;
        stall_i = 1'b0;
        we_i    = 1'b1;
        be_i    = 4'hF;
        addr_i  = 32'h10;
        wdata_i = 32'h0BAD0BAD;
        @(negedge clk_i);
        check_eq("rst_gnt", {31'b0, gnt_o}, 32'h0);
        check_eq("rst_rvalid", {31'b0, rvalid_o}, 32'h0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        sb.delete();
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i = 1'b0;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    initial begin
        logic g;
        rst_i = 1'b1; stall_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
        be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        @(posedge clk_i);
        #1;
        do_reset();
        do_reset();

        // Populate every word so later reads are well defined.
        for (int i = 0; i < MEM_WORDS; i++) begin
            xfer(1'b1, 4'hF, 32'(i * 4), 32'h5A5A0000 ^ (32'(i) * 32'h01010101));
        end
        idle(RESP_LAT + 1);

        // Write then read back.
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        xfer(1'b0, 4'h0, 32'h10, 32'h0);
        idle(RESP_LAT + 1);

        // Partial write merges byte lanes 0 and 2.
        xfer(1'b1, 4'hF, 32'h20, 32'h11223344);
        xfer(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        xfer(1'b0, 4'h0, 32'h20, 32'h0);
        idle(RESP_LAT + 1);
        check_eq("partial_model", mem_m[8], 32'h11BB33DD);

        // Eight reads with the request held high; grants follow the limit.
        for (int i = 0; i < 8; i++) xfer(1'b0, 4'hF, 32'(i * 4), 32'h0);
        idle(RESP_LAT + 1);

        // Stalled write must never be granted nor alter memory.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 4'hF, 32'h44, 32'h0BADBAD0, g);
        xfer(1'b0, 4'h0, 32'h44, 32'h0);
        xfer(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
        xfer(1'b0, 4'h0, 32'h00, 32'h0);
        idle(RESP_LAT + 1);

        // Reset with two reads in flight discards their responses.
        xfer(1'b0, 4'h0, 32'h04, 32'h0);
        xfer(1'b0, 4'h0, 32'h08, 32'h0);
        do_reset();
        idle(RESP_LAT + 2);
        xfer(1'b0, 4'h0, 32'h10, 32'h0);
        idle(RESP_LAT + 1);

        // Randomised traffic with aliased addresses, stalls and idle gaps.
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 32'($urandom_range(0, 255)), $urandom, g);
        end
        idle(RESP_LAT + 2);
        check_eq("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_cv32e40p_obi_mem_responder
`default_nettype wire
